// File: rtl/ooo_mem_responder.sv
// Memory-side responder: ID-tagged reads return after a per-request latency, possibly out of order.
// Define RESP_LFSR_LAT_EN to randomise read latency with an 8-bit LFSR; otherwise latency is MIN_LAT.
module ooo_mem_responder #(
  parameter int unsigned AW        = 8,
  parameter int unsigned DW        = 8,
  parameter int unsigned N         = 16,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned MIN_LAT   = 2,
  parameter logic [7:0]  LFSR_SEED = 8'hA5,
  localparam int unsigned IDW      = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           mem_read_req,
  input  logic [AW-1:0]  mem_read_addr,
  input  logic [IDW-1:0] mem_read_id,
  output logic           mem_read_ready,
  input  logic           mem_write_req,
  input  logic [AW-1:0]  mem_write_addr,
  input  logic [DW-1:0]  mem_write_data,
  output logic           mem_read_valid,
  output logic [IDW-1:0] mem_read_resp_id,
  output logic [DW-1:0]  mem_read_data,
  output logic           ovf_err
);

  localparam int unsigned SW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(MIN_LAT + 8);

  logic [DW-1:0]    mem_q       [2**AW];
  logic [DEPTH-1:0] slot_valid_q;
  logic [IDW-1:0]   slot_id_q   [DEPTH];
  logic [DW-1:0]    slot_data_q [DEPTH];
  logic [CW-1:0]    slot_cnt_q  [DEPTH];

  logic           valid_q;
  logic [IDW-1:0] resp_id_q;
  logic [DW-1:0]  resp_data_q;
  logic           ovf_q;

  logic          free_found, sel_found, accept;
  logic [SW-1:0] free_idx, sel_idx;
  logic [DW-1:0] rd_data;
  logic [CW-1:0] lat_m1;

`ifdef RESP_LFSR_LAT_EN
  logic [7:0] lfsr_q;

  // Fibonacci taps 8,6,5,4
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end
  end

  assign lat_m1 = CW'(MIN_LAT - 1) + CW'(lfsr_q[2:0]);
`else
  logic unused_seed;
  assign unused_seed = ^LFSR_SEED;
  assign lat_m1      = CW'(MIN_LAT - 1);
`endif

  // Lowest free slot for allocation and lowest expired slot for return, from registered state.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    sel_found  = 1'b0;
    sel_idx    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!slot_valid_q[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = SW'(i);
      end
      if (slot_valid_q[i] && (slot_cnt_q[i] == '0) && !sel_found) begin
        sel_found = 1'b1;
        sel_idx   = SW'(i);
      end
    end
  end

  assign mem_read_ready = free_found;
  assign accept         = mem_read_req & free_found;
  assign rd_data        = (mem_write_req && (mem_write_addr == mem_read_addr)) ?
                          mem_write_data : mem_q[mem_read_addr];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 2**AW; i++) begin
        mem_q[i] <= '0;
      end
    end else if (mem_write_req) begin
      mem_q[mem_write_addr] <= mem_write_data;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      slot_valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        slot_id_q[i]   <= '0;
        slot_data_q[i] <= '0;
        slot_cnt_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (slot_valid_q[i] && (slot_cnt_q[i] != '0)) begin
          slot_cnt_q[i] <= slot_cnt_q[i] - CW'(1);
        end
        if (sel_found && (sel_idx == SW'(i))) begin
          slot_valid_q[i] <= 1'b0;
        end
        // The allocated slot was free, so it can never also be the returning one.
        if (accept && (free_idx == SW'(i))) begin
          slot_valid_q[i] <= 1'b1;
          slot_id_q[i]    <= mem_read_id;
          slot_data_q[i]  <= rd_data;
          slot_cnt_q[i]   <= lat_m1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_q     <= 1'b0;
      resp_id_q   <= '0;
      resp_data_q <= '0;
      ovf_q       <= 1'b0;
    end else begin
      valid_q <= sel_found;
      if (sel_found) begin
        resp_id_q   <= slot_id_q[sel_idx];
        resp_data_q <= slot_data_q[sel_idx];
      end
      if (mem_read_req && !free_found) begin
        ovf_q <= 1'b1;
      end
    end
  end

  assign mem_read_valid   = valid_q;
  assign mem_read_resp_id = resp_id_q;
  assign mem_read_data    = resp_data_q;
  assign ovf_err          = ovf_q;

endmodule

// File: tb/tb_ooo_mem_responder.sv
// Bench for ooo_mem_responder: a MIN_LAT=2 instance for function and a MIN_LAT=8 instance
// sharing the same stimulus so the pending-slot pool can be filled.
module tb_ooo_mem_responder;

  localparam int AW       = 8;
  localparam int DW       = 8;
  localparam int N        = 16;
  localparam int IDW      = 4;
  localparam int DEPTH    = 4;
  localparam int LAT      = 2;
  localparam int SLOW_LAT = 8;

  logic           clk = 1'b0;
  logic           rstn = 1'b0;
  logic           read_req = 1'b0;
  logic [AW-1:0]  read_addr = '0;
  logic [IDW-1:0] read_id = '0;
  logic           write_req = 1'b0;
  logic [AW-1:0]  write_addr = '0;
  logic [DW-1:0]  write_data = '0;

  logic           f_ready, f_valid, f_ovf;
  logic [IDW-1:0] f_id;
  logic [DW-1:0]  f_data;
  logic           s_ready, s_valid, s_ovf;
  logic [IDW-1:0] s_id;
  logic [DW-1:0]  s_data;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ooo_mem_responder #(.AW(AW), .DW(DW), .N(N), .DEPTH(DEPTH), .MIN_LAT(LAT)) dut (
    .clk(clk), .rstn(rstn),
    .mem_read_req(read_req), .mem_read_addr(read_addr), .mem_read_id(read_id),
    .mem_read_ready(f_ready),
    .mem_write_req(write_req), .mem_write_addr(write_addr), .mem_write_data(write_data),
    .mem_read_valid(f_valid), .mem_read_resp_id(f_id), .mem_read_data(f_data),
    .ovf_err(f_ovf)
  );

  ooo_mem_responder #(.AW(AW), .DW(DW), .N(N), .DEPTH(DEPTH), .MIN_LAT(SLOW_LAT)) dut_slow (
    .clk(clk), .rstn(rstn),
    .mem_read_req(read_req), .mem_read_addr(read_addr), .mem_read_id(read_id),
    .mem_read_ready(s_ready),
    .mem_write_req(write_req), .mem_write_addr(write_addr), .mem_write_data(write_data),
    .mem_read_valid(s_valid), .mem_read_resp_id(s_id), .mem_read_data(s_data),
    .ovf_err(s_ovf)
  );

  task automatic idle();
    read_req  = 1'b0;
    write_req = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle();
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  // Observe the fast instance for a bounded window starting in the current cycle.
  task automatic scan_fast(input int cycles, output int first, output int cnt,
                           output logic [IDW-1:0] gid, output logic [DW-1:0] gdata);
    first = -1;
    cnt   = 0;
    gid   = '0;
    gdata = '0;
    for (int c = 0; c < cycles; c++) begin
      if (f_valid) begin
        cnt++;
        if (first < 0) begin
          first = c;
          gid   = f_id;
          gdata = f_data;
        end
      end
      tick();
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_vec += 6;
    if (f_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", f_valid); end
    if (f_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b want 1", f_ready); end
    if (f_ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf got %b want 0", f_ovf); end
    if (f_id !== '0) begin n_err++; $display("FAIL reset_id got %0h want 0", f_id); end
    if (f_data !== '0) begin n_err++; $display("FAIL reset_data got %0h want 0", f_data); end
    if (s_ready !== 1'b1) begin n_err++; $display("FAIL reset_slow_ready got %b want 1", s_ready); end
  endtask

  task automatic test_basic_read();
    int first, cnt;
    logic [IDW-1:0] gid;
    logic [DW-1:0]  gd;
    write_req = 1'b1; write_addr = 8'h10; write_data = 8'h3C;
    tick();
    idle();
    read_req = 1'b1; read_addr = 8'h10; read_id = 4'd5;
    tick();
    idle();
    scan_fast(12, first, cnt, gid, gd);
    n_vec += 4;
`ifdef RESP_LFSR_LAT_EN
    if (first < LAT || first > LAT + 7) begin
      n_err++; $display("FAIL basic_latency got %0d want %0d..%0d", first, LAT, LAT + 7);
    end
`else
    if (first != LAT) begin n_err++; $display("FAIL basic_latency got %0d want %0d", first, LAT); end
`endif
    if (cnt != 1) begin n_err++; $display("FAIL basic_valid_cycles got %0d want 1", cnt); end
    if (gid !== 4'd5) begin n_err++; $display("FAIL basic_id got %0d want 5", gid); end
    if (gd !== 8'h3C) begin n_err++; $display("FAIL basic_data got %0h want 3c", gd); end
  endtask

  task automatic test_bypass();
    int first, cnt;
    logic [IDW-1:0] gid;
    logic [DW-1:0]  gd;
    write_req = 1'b1; write_addr = 8'h20; write_data = 8'h77;
    read_req  = 1'b1; read_addr  = 8'h20; read_id    = 4'd1;
    tick();
    idle();
    scan_fast(12, first, cnt, gid, gd);
    n_vec += 3;
    if (cnt != 1) begin n_err++; $display("FAIL bypass_count got %0d want 1", cnt); end
    if (gid !== 4'd1) begin n_err++; $display("FAIL bypass_id got %0d want 1", gid); end
    if (gd !== 8'h77) begin n_err++; $display("FAIL bypass_data got %0h want 77", gd); end
  endtask

  task automatic test_full_overflow();
    int cnt = 0;
    logic [15:0] seen = '0;
    do_reset();
    n_vec++;
    if (s_ovf !== 1'b0) begin n_err++; $display("FAIL full_ovf_initial got %b want 0", s_ovf); end
    for (int i = 0; i < 5; i++) begin
      read_req = 1'b1; read_addr = 8'h40; read_id = IDW'(i);
      n_vec++;
      if (s_ready !== (i < DEPTH)) begin
        n_err++; $display("FAIL full_ready_%0d got %b want %b", i, s_ready, (i < DEPTH));
      end
      tick();
    end
    idle();
    n_vec += 2;
    if (s_ovf !== 1'b1) begin n_err++; $display("FAIL full_ovf_set got %b want 1", s_ovf); end
    if (s_ready !== 1'b0) begin n_err++; $display("FAIL full_ready_after got %b want 0", s_ready); end
    for (int c = 0; c < 24; c++) begin
      if (s_valid) begin
        cnt++;
        seen[s_id] = 1'b1;
      end
      tick();
    end
    n_vec += 4;
    if (cnt != DEPTH) begin n_err++; $display("FAIL full_resp_count got %0d want %0d", cnt, DEPTH); end
    if (seen !== 16'h000F) begin n_err++; $display("FAIL full_resp_ids got %h want 000f", seen); end
    if (s_ovf !== 1'b1) begin n_err++; $display("FAIL full_ovf_sticky got %b want 1", s_ovf); end
    if (s_ready !== 1'b1) begin n_err++; $display("FAIL full_ready_drained got %b want 1", s_ready); end
    do_reset();
    n_vec++;
    if (s_ovf !== 1'b0) begin n_err++; $display("FAIL full_ovf_cleared got %b want 0", s_ovf); end
  endtask

  task automatic test_reset_pending();
    int vcnt = 0;
    int first, cnt;
    logic [IDW-1:0] gid;
    logic [DW-1:0]  gd;
    write_req = 1'b1; write_addr = 8'h30; write_data = 8'h55;
    tick();
    idle();
    for (int i = 0; i < 3; i++) begin
      read_req = 1'b1; read_addr = 8'h30; read_id = IDW'(7 + i);
      tick();
    end
    idle();
    #2 rstn = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (f_valid || s_valid) vcnt++;
      tick();
    end
    n_vec += 3;
    if (vcnt != 0) begin n_err++; $display("FAIL rst_pending_resp got %0d want 0", vcnt); end
    if (s_ready !== 1'b1) begin n_err++; $display("FAIL rst_pending_ready got %b want 1", s_ready); end
    if (f_ready !== 1'b1) begin n_err++; $display("FAIL rst_fast_ready got %b want 1", f_ready); end
    read_req = 1'b1; read_addr = 8'h30; read_id = 4'd2;
    tick();
    idle();
    scan_fast(12, first, cnt, gid, gd);
    n_vec += 2;
    if (cnt != 1) begin n_err++; $display("FAIL rst_readback_count got %0d want 1", cnt); end
    if (gd !== 8'h00) begin n_err++; $display("FAIL rst_readback_data got %0h want 0", gd); end
  endtask

`ifndef RESP_LFSR_LAT_EN
  typedef struct {
    logic [IDW-1:0] id;
    logic [DW-1:0]  data;
    int             due;
  } pend_t;

  // Reference: a read accepted at edge a returns at the output after edge a+LAT, in accept order,
  // and holds a slot while a <= current edge < a+LAT.
  task automatic test_random();
    logic [DW-1:0] mmem [2**AW];
    pend_t q[$];
    pend_t p;
    int edge_n = 0;
    int occ;
    logic exp_ready, exp_valid, ovf_m;
    do_reset();
    for (int i = 0; i < 2**AW; i++) mmem[i] = '0;
    ovf_m = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      occ = 0;
      foreach (q[k]) if (q[k].due > edge_n) occ++;
      exp_ready = (occ < DEPTH);
      exp_valid = (q.size() > 0) && (q[0].due == edge_n);
      n_vec += 3;
      if (f_ready !== exp_ready) begin
        n_err++; $display("FAIL rand_ready cyc %0d got %b want %b", cyc, f_ready, exp_ready);
      end
      if (f_valid !== exp_valid) begin
        n_err++; $display("FAIL rand_valid cyc %0d got %b want %b", cyc, f_valid, exp_valid);
      end
      if (f_ovf !== ovf_m) begin
        n_err++; $display("FAIL rand_ovf cyc %0d got %b want %b", cyc, f_ovf, ovf_m);
      end
      if (exp_valid) begin
        p = q.pop_front();
        n_vec += 2;
        if (f_id !== p.id) begin
          n_err++; $display("FAIL rand_id cyc %0d got %0d want %0d", cyc, f_id, p.id);
        end
        if (f_data !== p.data) begin
          n_err++; $display("FAIL rand_data cyc %0d got %0h want %0h", cyc, f_data, p.data);
        end
      end
      read_req   = ($urandom_range(0, 2) != 0);
      read_addr  = AW'($urandom_range(0, 15));
      read_id    = IDW'($urandom);
      write_req  = ($urandom_range(0, 1) != 0);
      write_addr = AW'($urandom_range(0, 15));
      write_data = DW'($urandom);
      @(posedge clk);
      edge_n++;
      if (read_req) begin
        if (exp_ready) begin
          p.id   = read_id;
          p.data = (write_req && write_addr == read_addr) ? write_data : mmem[read_addr];
          p.due  = edge_n + LAT;
          q.push_back(p);
        end else begin
          ovf_m = 1'b1;
        end
      end
      if (write_req) mmem[write_addr] = write_data;
      @(negedge clk);
    end
    idle();
    repeat (LAT + 2) tick();
  endtask
`else
  task automatic test_ooo();
    int got_cnt [16];
    logic [DW-1:0] got_data [16];
    int order [$];
    int issued = 0;
    int in_order = 1;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      got_cnt[i] = 0;
      got_data[i] = '0;
      write_req = 1'b1; write_addr = AW'(i * 3); write_data = DW'(8'h5A ^ (i * 17));
      tick();
    end
    idle();
    for (int c = 0; c < 200 && (issued < 16 || order.size() < 16); c++) begin
      if (f_valid) begin
        got_cnt[f_id]++;
        got_data[f_id] = f_data;
        order.push_back(int'(f_id));
      end
      read_req = (issued < 16) && f_ready;
      read_addr = AW'(issued * 3);
      read_id = IDW'(issued);
      if (read_req) issued++;
      tick();
    end
    idle();
    for (int i = 0; i < 16; i++) begin
      n_vec += 2;
      if (got_cnt[i] != 1) begin n_err++; $display("FAIL ooo_count id %0d got %0d want 1", i, got_cnt[i]); end
      if (got_data[i] !== DW'(8'h5A ^ (i * 17))) begin
        n_err++; $display("FAIL ooo_data id %0d got %0h want %0h", i, got_data[i], DW'(8'h5A ^ (i * 17)));
      end
    end
    foreach (order[k]) if (order[k] != k) in_order = 0;
    n_vec++;
    if (in_order != 0) begin n_err++; $display("FAIL ooo_order got in-order want reordered"); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic_read();
    test_bypass();
    test_full_overflow();
    test_reset_pending();
`ifndef RESP_LFSR_LAT_EN
    test_random();
`else
    test_ooo();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
